// File: rtl/dma_streamer.sv
// Descriptor executor: splits one DMA descriptor into AXI-legal burst requests
// (4 KB page safe, MAX_BURST capped, FIXED bursts capped at 16 beats).
module dma_streamer #(
  parameter int NUM_DESC  = 2,
  parameter int ADDR_W    = 32,
  parameter int BYTES_W   = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int IDX_W     = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         str_valid_i,
  input  logic [IDX_W-1:0]             str_idx_i,
  output logic                         str_done_o,
  output logic                         busy_o,
  input  logic [NUM_DESC*ADDR_W-1:0]   desc_addr_i,
  input  logic [NUM_DESC*BYTES_W-1:0]  desc_bytes_i,
  input  logic [NUM_DESC-1:0]          desc_fixed_i,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic [ADDR_W-1:0]            req_addr_o,
  output logic [7:0]                   req_len_o,
  output logic [2:0]                   req_size_o,
  output logic [1:0]                   req_burst_o,
  output logic                         req_last_o
);

  localparam int BEAT_B = DATA_W / 8;
  localparam int SZ     = $clog2(BEAT_B);
  localparam int CW     = (BYTES_W > 13) ? BYTES_W : 13;
  localparam logic [BYTES_W-1:0] BYTE_MASK = BYTES_W'(BEAT_B - 1);
  localparam logic [ADDR_W-1:0]  ADDR_MASK = ADDR_W'(BEAT_B - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Beats for the next burst: FIXED caps at 16, INCR stops at the 4 KB page edge.
  function automatic logic [8:0] calc_beats(input logic [11:0] page_off,
                                            input logic [BYTES_W-1:0] rem,
                                            input logic fixed);
    logic [12:0]   page_b;
    logic [CW-1:0] lim;
    logic [CW-1:0] rw;
    page_b = (13'd4096 - {1'b0, page_off}) >> SZ;
    if (fixed) begin
      lim = CW'(16);
    end else if (page_b < 13'(MAX_BURST)) begin
      lim = CW'(page_b);
    end else begin
      lim = CW'(MAX_BURST);
    end
    rw = CW'(rem);
    calc_beats = (rw < lim) ? 9'(rw) : 9'(lim);
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [BYTES_W-1:0]  rem_r, rem_s;
  logic                fixed_r, fixed_s;
  logic                aborted_r, aborted_s;
  logic [7:0]          len_r;
  logic [1:0]          burst_r;
  logic                last_r;
  logic                valid_r;
  logic                done_r;
  logic                busy_r;

  logic [ADDR_W-1:0]   sel_addr_s;
  logic [BYTES_W-1:0]  sel_bytes_s;
  logic [BYTES_W-1:0]  sel_rem_s;
  logic                sel_fixed_s;
  logic                hs_s;
  logic [8:0]          cur_bt_s;
  logic [8:0]          nxt_bt_s;
  logic                nxt_last_s;
  logic                load_s;

  assign sel_addr_s  = desc_addr_i[int'(str_idx_i)*ADDR_W +: ADDR_W];
  assign sel_bytes_s = desc_bytes_i[int'(str_idx_i)*BYTES_W +: BYTES_W];
  assign sel_fixed_s = desc_fixed_i[str_idx_i];
  // Round up to whole beats without widening: a partial last beat adds one.
  assign sel_rem_s   = (sel_bytes_s >> SZ) + BYTES_W'(|(sel_bytes_s & BYTE_MASK));

  assign hs_s       = valid_r & req_ready_i;
  assign cur_bt_s   = {1'b0, len_r} + 9'd1;
  assign nxt_bt_s   = calc_beats(addr_s[11:0], rem_s, fixed_s);
  assign nxt_last_s = (CW'(rem_s) == CW'(nxt_bt_s));
  assign load_s     = (state_s == S_ISSUE) && ((state_r != S_ISSUE) || hs_s);

  // Next-state and working-register update.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    rem_s     = rem_r;
    fixed_s   = fixed_r;
    aborted_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (str_valid_i) begin
          addr_s  = sel_addr_s & ~ADDR_MASK;
          rem_s   = sel_rem_s;
          fixed_s = sel_fixed_s;
          if (sel_rem_s != {BYTES_W{1'b0}}) begin
            state_s = S_ISSUE;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        // A dropped request is remembered so the pending burst can still complete.
        aborted_s = aborted_r | ~str_valid_i;
        if (hs_s) begin
          rem_s = rem_r - BYTES_W'(cur_bt_s);
          if (fixed_r) begin
            addr_s = addr_r;
          end else begin
            addr_s = addr_r + (ADDR_W'(cur_bt_s) << SZ);
          end
          if (aborted_s) begin
            state_s = S_IDLE;
          end else if (last_r) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ISSUE;
          end
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, working registers and registered request/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      rem_r     <= {BYTES_W{1'b0}};
      fixed_r   <= 1'b0;
      aborted_r <= 1'b0;
      len_r     <= 8'd0;
      burst_r   <= 2'b00;
      last_r    <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      rem_r     <= rem_s;
      fixed_r   <= fixed_s;
      aborted_r <= aborted_s && (state_s == S_ISSUE);
      valid_r   <= (state_s == S_ISSUE);
      done_r    <= (state_s == S_DONE);
      busy_r    <= (state_s != S_IDLE);
      // Request fields only move on entry or after a handshake, so they hold under backpressure.
      if (load_s) begin
        len_r   <= 8'(nxt_bt_s - 9'd1);
        last_r  <= nxt_last_s;
        burst_r <= fixed_s ? 2'b00 : 2'b01;
      end else begin
        len_r   <= len_r;
        last_r  <= last_r;
        burst_r <= burst_r;
      end
    end
  end

  assign str_done_o  = done_r;
  assign busy_o      = busy_r;
  assign req_valid_o = valid_r;
  assign req_addr_o  = addr_r;
  assign req_len_o   = len_r;
  assign req_size_o  = 3'(SZ);
  assign req_burst_o = burst_r;
  assign req_last_o  = last_r;

endmodule

// File: tb/tb_dma_streamer.sv
// Directed self-checking bench for dma_streamer (DATA_W=32, two descriptors).
module tb_dma_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        str_valid;
  logic [0:0]  str_idx;
  logic        str_done;
  logic        busy;
  logic [63:0] desc_addr;
  logic [63:0] desc_bytes;
  logic [1:0]  desc_fixed;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic        req_last;

  int tests_run = 0;
  int fail_count = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int hs_cyc = -1;
  int valid_cnt = 0;
  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];
  logic [1:0]  q_burst[$];
  logic        q_last[$];

  dma_streamer dut (
    .clk(clk), .rst(rst),
    .str_valid_i(str_valid), .str_idx_i(str_idx), .str_done_o(str_done), .busy_o(busy),
    .desc_addr_i(desc_addr), .desc_bytes_i(desc_bytes), .desc_fixed_i(desc_fixed),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
    .req_len_o(req_len), .req_size_o(req_size), .req_burst_o(req_burst), .req_last_o(req_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted bursts and done pulses away from the active edge.
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      q_addr.push_back(req_addr);
      q_len.push_back(req_len);
      q_burst.push_back(req_burst);
      q_last.push_back(req_last);
      hs_cyc = cyc;
    end
    if (str_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (req_valid) valid_cnt = valid_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      fail_count = fail_count + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int idx, input logic [31:0] a, input logic [31:0] b, input logic fx);
    desc_addr[idx*32 +: 32]  = a;
    desc_bytes[idx*32 +: 32] = b;
    desc_fixed[idx]          = fx;
  endtask

  task automatic check_req(input string tag, input int k, input logic [31:0] a,
                           input logic [7:0] len, input logic [1:0] bu, input logic last);
    check_eq({tag, "_addr"},  q_addr[k],  a);
    check_eq({tag, "_len"},   32'(q_len[k]),   32'(len));
    check_eq({tag, "_burst"}, 32'(q_burst[k]), 32'(bu));
    check_eq({tag, "_last"},  32'(q_last[k]),  32'(last));
  endtask

  // Launch descriptor idx with ready high, wait (bounded) for done, then release.
  task automatic run_desc(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic fx, input int exp_n, output int base);
    int d0;
    set_desc(idx, a, b, fx);
    base = q_addr.size();
    d0 = done_cnt;
    str_idx = 1'(idx);
    str_valid = 1'b1;
    step();
    check_eq({tag, "_first_valid"}, 32'(req_valid), 32'd1);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) step();
    str_valid = 1'b0;
    step();
    step();
    check_eq({tag, "_done_once"}, done_cnt - d0, 32'd1);
    check_eq({tag, "_done_lat"}, done_cyc, hs_cyc + 1);
    check_eq({tag, "_nreq"}, q_addr.size() - base, exp_n);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int d0;
    int v0;
    rst = 1'b1;
    str_valid = 1'b0;
    str_idx = 1'b0;
    req_ready = 1'b1;
    desc_addr = 64'd0;
    desc_bytes = 64'd0;
    desc_fixed = 2'b00;
    step();
    step();
    check_eq("rst_valid", 32'(req_valid), 32'd0);
    check_eq("rst_done",  32'(str_done),  32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_addr",  req_addr,       32'd0);
    check_eq("rst_len",   32'(req_len),   32'd0);
    check_eq("rst_burst", 32'(req_burst), 32'd0);
    check_eq("rst_last",  32'(req_last),  32'd0);
    check_eq("rst_size",  32'(req_size),  32'd2);
    rst = 1'b0;
    step();

    run_desc("single", 0, 32'h0000_1000, 32'd64, 1'b0, 1, base);
    check_req("single_r0", base, 32'h0000_1000, 8'd15, 2'b01, 1'b1);

    run_desc("page", 1, 32'h0000_0FF0, 32'd64, 1'b0, 2, base);
    check_req("page_r0", base,     32'h0000_0FF0, 8'd3,  2'b01, 1'b0);
    check_req("page_r1", base + 1, 32'h0000_1000, 8'd11, 2'b01, 1'b1);

    run_desc("maxb", 0, 32'h0000_2000, 32'd2048, 1'b0, 2, base);
    check_req("maxb_r0", base,     32'h0000_2000, 8'd255, 2'b01, 1'b0);
    check_req("maxb_r1", base + 1, 32'h0000_2400, 8'd255, 2'b01, 1'b1);

    run_desc("fixed", 1, 32'h0000_3004, 32'd97, 1'b1, 2, base);
    check_req("fixed_r0", base,     32'h0000_3004, 8'd15, 2'b00, 1'b0);
    check_req("fixed_r1", base + 1, 32'h0000_3004, 8'd8,  2'b00, 1'b1);

    run_desc("unalig", 0, 32'h0000_1003, 32'd5, 1'b0, 1, base);
    check_req("unalig_r0", base, 32'h0000_1000, 8'd1, 2'b01, 1'b1);

    // Backpressure: fields hold for 5 cycles even though the descriptor changes.
    req_ready = 1'b0;
    set_desc(1, 32'h0000_0FF0, 32'd64, 1'b0);
    base = q_addr.size();
    d0 = done_cnt;
    str_idx = 1'b1;
    str_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(req_valid), 32'd1);
      check_eq("bp_addr",  req_addr,       32'h0000_0FF0);
      check_eq("bp_len",   32'(req_len),   32'd3);
      check_eq("bp_last",  32'(req_last),  32'd0);
      set_desc(1, 32'h0000_5000, 32'd400, 1'b1);
      step();
    end
    req_ready = 1'b1;
    for (int i = 0; i < 100 && done_cnt == d0; i++) step();
    str_valid = 1'b0;
    step();
    step();
    check_eq("bp_done_once", done_cnt - d0, 32'd1);
    check_eq("bp_nreq", q_addr.size() - base, 32'd2);
    check_req("bp_r0", base,     32'h0000_0FF0, 8'd3,  2'b01, 1'b0);
    check_req("bp_r1", base + 1, 32'h0000_1000, 8'd11, 2'b01, 1'b1);

    // Zero bytes: done at t+1 with no request.
    set_desc(0, 32'h0000_1000, 32'd0, 1'b0);
    d0 = done_cnt;
    v0 = valid_cnt;
    str_idx = 1'b0;
    str_valid = 1'b1;
    step();
    check_eq("zero_done",  32'(str_done),  32'd1);
    check_eq("zero_valid", 32'(req_valid), 32'd0);
    str_valid = 1'b0;
    step();
    step();
    check_eq("zero_done_once", done_cnt - d0, 32'd1);
    check_eq("zero_no_req", valid_cnt - v0, 32'd0);

    // Abort with a request pending: hold until ready, then idle with no done.
    req_ready = 1'b0;
    set_desc(1, 32'h0000_0FF0, 32'd64, 1'b0);
    base = q_addr.size();
    d0 = done_cnt;
    str_idx = 1'b1;
    str_valid = 1'b1;
    step();
    str_valid = 1'b0;
    step();
    check_eq("abort_hold_valid", 32'(req_valid), 32'd1);
    check_eq("abort_hold_addr",  req_addr,       32'h0000_0FF0);
    step();
    req_ready = 1'b1;
    step();
    check_eq("abort_valid_drop", 32'(req_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    step();
    step();
    step();
    check_eq("abort_no_done", done_cnt - d0, 32'd0);
    check_eq("abort_nreq", q_addr.size() - base, 32'd1);

    // Reset in the middle of ISSUE.
    req_ready = 1'b0;
    set_desc(0, 32'h0000_2000, 32'd2048, 1'b0);
    d0 = done_cnt;
    str_idx = 1'b0;
    str_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    str_valid = 1'b0;
    step();
    check_eq("rstmid_valid", 32'(req_valid), 32'd0);
    check_eq("rstmid_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    req_ready = 1'b1;
    step();
    step();
    step();
    check_eq("rstmid_no_done", done_cnt - d0, 32'd0);
    check_eq("rstmid_still_idle", 32'(req_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
